// File: rtl/ccu25_link_responder.sv
// ccu25_link_responder: CCU25 endpoint of the 8-bit strobed parallel link.
// Decodes command/data bytes from the bridge into 16-bit register-bus
// accesses and returns read data as two strobed bytes on the link.
// Optional feature: define CCU25_TIMEOUT_EN to abort write frames that stall
// for TIMEOUT_CYC cycles between bytes.
module ccu25_link_responder #(
    parameter int STROBE_W    = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        strobe_in,
    input  logic [7:0]  link_data_in,
    output logic [7:0]  link_data_out,
    output logic        link_data_oe,
    output logic        strobe_out,
    output logic [6:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic        frame_err,
    input  logic        err_clr
);

    typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, RD_WAIT, TX} state_t;

    // Per-byte phase counter: 0 = SETUP, 1..STROBE_W = STROBE, STROBE_W+1 = HOLD
    localparam logic [4:0] STB_LAST = 5'(STROBE_W);
    localparam logic [4:0] HOLD_PH  = 5'(STROBE_W + 1);

    if (STROBE_W < 1 || STROBE_W > 15 || TIMEOUT_CYC < 4 || TIMEOUT_CYC > 65535) begin : g_param_chk
        $error("ccu25_link_responder: parameter out of range");
    end

    state_t      state_q;
    logic        sync1_q, sync2_q, prev_q;
    logic [4:0]  ph_q;
    logic        byte_q;
    logic [7:0]  lo_q;
    logic [7:0]  dout_q;
    logic        oe_q, stb_q;
    logic [6:0]  addr_q;
    logic [15:0] wdata_q;
    logic        we_q, re_q;
    logic        err_q;

    logic        rise;
    logic        in_wr;
    logic        drop_err;
    logic        tmo_hit;

    // Bring the asynchronous strobe into clk and keep one delayed copy for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= strobe_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise     = sync2_q & ~prev_q;
    assign in_wr    = (state_q == WR_HI) || (state_q == WR_LO);
    assign drop_err = rise & ((state_q == RD_WAIT) || (state_q == TX));

`ifdef CCU25_TIMEOUT_EN
    logic [15:0] tmo_q;

    // An accepted byte always wins over an expiring counter on the same edge
    assign tmo_hit = in_wr & ~rise & (tmo_q == 16'(TIMEOUT_CYC - 1));

    // Idle-gap counter: restarts on every accepted byte, runs only inside a write frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= 16'd0;
        end else if (rise || !in_wr) begin
            tmo_q <= 16'd0;
        end else begin
            tmo_q <= tmo_q + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Sticky frame error; a new error in the same cycle beats err_clr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (drop_err || tmo_hit) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    // Frame decode, register-bus strobes and response serializer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ph_q    <= 5'd0;
            byte_q  <= 1'b0;
            lo_q    <= 8'd0;
            dout_q  <= 8'd0;
            oe_q    <= 1'b0;
            stb_q   <= 1'b0;
            addr_q  <= 7'd0;
            wdata_q <= 16'd0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
        end else begin
            we_q <= 1'b0;
            re_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        addr_q <= link_data_in[6:0];
                        if (link_data_in[7]) begin
                            re_q    <= 1'b1;
                            state_q <= RD_WAIT;
                        end else begin
                            state_q <= WR_HI;
                        end
                    end
                end
                WR_HI: begin
                    if (rise) begin
                        wdata_q[15:8] <= link_data_in;
                        state_q       <= WR_LO;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                    end
                end
                WR_LO: begin
                    if (rise) begin
                        wdata_q[7:0] <= link_data_in;
                        we_q         <= 1'b1;
                        state_q      <= IDLE;
                    end else if (tmo_hit) begin
                        state_q <= IDLE;
                    end
                end
                RD_WAIT: begin
                    // First RD_WAIT cycle is the reg_re cycle; read data is valid the cycle after
                    if (!re_q) begin
                        dout_q  <= reg_rdata[15:8];
                        lo_q    <= reg_rdata[7:0];
                        oe_q    <= 1'b1;
                        ph_q    <= 5'd0;
                        byte_q  <= 1'b0;
                        state_q <= TX;
                    end
                end
                TX: begin
                    if (ph_q == HOLD_PH) begin
                        stb_q <= 1'b0;
                        ph_q  <= 5'd0;
                        if (!byte_q) begin
                            byte_q <= 1'b1;
                            dout_q <= lo_q;
                        end else begin
                            oe_q    <= 1'b0;
                            dout_q  <= 8'd0;
                            state_q <= IDLE;
                        end
                    end else begin
                        ph_q  <= ph_q + 5'd1;
                        stb_q <= (ph_q < STB_LAST);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign link_data_out = dout_q;
    assign link_data_oe  = oe_q;
    assign strobe_out    = stb_q;
    assign reg_addr      = addr_q;
    assign reg_wdata     = wdata_q;
    assign reg_we        = we_q;
    assign reg_re        = re_q;
    assign frame_err     = err_q;

endmodule

// File: tb/tb_ccu25_link_responder.sv
// tb_ccu25_link_responder: randomized frames against a register-map model.
module tb_ccu25_link_responder;

    localparam int SW  = 4;
    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe_in = 1'b0;
    logic [7:0]  link_data_in = 8'd0;
    logic        err_clr = 1'b0;
    logic [7:0]  link_data_out;
    logic        link_data_oe;
    logic        strobe_out;
    logic [6:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic [15:0] reg_rdata;
    logic        frame_err;

    int n_chk  = 0;
    int n_pass = 0;

    ccu25_link_responder #(.STROBE_W(SW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .strobe_in(strobe_in), .link_data_in(link_data_in),
        .link_data_out(link_data_out), .link_data_oe(link_data_oe), .strobe_out(strobe_out),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .frame_err(frame_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        return 16'(i * 40503 + 4660);
    endfunction

    // Register file on the bus: data is valid only in the cycle after reg_re
    logic [15:0] mem [128];
    logic        mem_rdy;
    always @(posedge clk) begin
        if (mem_rdy !== 1'b1) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
            mem_rdy <= 1'b1;
        end else if (reg_we) begin
            mem[reg_addr] <= reg_wdata;
        end
        reg_rdata <= reg_re ? mem[reg_addr] : 16'($urandom);
    end

    // Reference contents of the register map
    logic [15:0] exp_mem [128];

    // Link / bus observers
    logic [22:0] we_q [$];
    logic [6:0]  re_q [$];
    logic [7:0]  rx_q [$];
    int          run_q [$];
    int          re_cnt = 0, oe_cnt = 0, bad_cnt = 0, run = 0;
    logic        stb_prev = 1'b0;
    logic [7:0]  dat_prev = 8'd0;

    always @(negedge clk) begin
        if (rst) begin
            run      <= 0;
            stb_prev <= 1'b0;
        end else begin
            if (reg_we) we_q.push_back({reg_addr, reg_wdata});
            if (reg_re) begin
                re_cnt <= re_cnt + 1;
                re_q.push_back(reg_addr);
            end
            if (link_data_oe) oe_cnt <= oe_cnt + 1;
            if (strobe_out && !link_data_oe) bad_cnt <= bad_cnt + 1;
            if (strobe_out && stb_prev && link_data_out != dat_prev) bad_cnt <= bad_cnt + 1;
            if (strobe_out && !stb_prev) rx_q.push_back(link_data_out);
            if (strobe_out) run <= run + 1;
            else if (stb_prev) begin
                run_q.push_back(run);
                run <= 0;
            end
            stb_prev <= strobe_out;
            dat_prev <= link_data_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic send_byte(input logic [7:0] b);
        link_data_in = b;
        strobe_in    = 1'b1;
        repeat (3 + $urandom_range(0, 2)) @(negedge clk);
        strobe_in    = 1'b0;
        link_data_in = 8'($urandom);
        repeat (3 + $urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic clear_obs();
        we_q.delete(); re_q.delete(); rx_q.delete(); run_q.delete();
    endtask

    task automatic wr_frame(input logic [6:0] a, input logic [15:0] d);
        int re0;
        logic [22:0] got;
        clear_obs();
        re0 = re_cnt;
        send_byte({1'b0, a});
        send_byte(d[15:8]);
        send_byte(d[7:0]);
        repeat (2) @(negedge clk);
        chk("wr_we_cnt", we_q.size(), 1);
        got = '1;
        if (we_q.size() > 0) got = we_q.pop_front();
        chk("wr_addr_data", got, {a, d});
        chk("wr_no_re", re_cnt - re0, 0);
        chk("wr_err", frame_err, 0);
        exp_mem[a] = d;
    endtask

    task automatic rsp_check(input logic [6:0] a, input int oe0, input int re0, input int bad0);
        logic [15:0] e;
        logic [7:0]  b;
        logic [6:0]  ra;
        e = exp_mem[a];
        chk("rd_re_cnt", re_cnt - re0, 1);
        ra = '1;
        if (re_q.size() > 0) ra = re_q.pop_front();
        chk("rd_re_addr", ra, a);
        chk("rd_nbytes", rx_q.size(), 2);
        b = 8'hxx;
        if (rx_q.size() > 0) b = rx_q.pop_front();
        chk("rd_hi", b, e[15:8]);
        b = 8'hxx;
        if (rx_q.size() > 0) b = rx_q.pop_front();
        chk("rd_lo", b, e[7:0]);
        chk("rd_oe_cycles", oe_cnt - oe0, 2 * (SW + 2));
        chk("rd_stb_runs", run_q.size(), 2);
        while (run_q.size() > 0) chk("rd_stb_width", run_q.pop_front(), SW);
        chk("rd_no_we", we_q.size(), 0);
        chk("rd_shape", bad_cnt - bad0, 0);
    endtask

    task automatic rd_frame(input logic [6:0] a);
        int oe0, re0, bad0;
        clear_obs();
        oe0 = oe_cnt; re0 = re_cnt; bad0 = bad_cnt;
        send_byte({1'b1, a});
        repeat (30) @(negedge clk);
        rsp_check(a, oe0, re0, bad0);
        chk("rd_err", frame_err, 0);
    endtask

    // Sends a read command by hand and returns once the response is on the wire
    task automatic start_read(input logic [6:0] a);
        link_data_in = {1'b1, a};
        strobe_in    = 1'b1;
        repeat (3) @(negedge clk);
        strobe_in    = 1'b0;
        for (int i = 0; i < 20 && !link_data_oe; i++) @(negedge clk);
        chk("tx_entered", link_data_oe, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int oe0, re0, bad0;
        logic [6:0] a;
        for (int i = 0; i < 128; i++) exp_mem[i] = init_val(i);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", link_data_out, 0);
        chk("rst_oe", link_data_oe, 0);
        chk("rst_stb", strobe_out, 0);
        chk("rst_addr", reg_addr, 0);
        chk("rst_wdata", reg_wdata, 0);
        chk("rst_we", reg_we, 0);
        chk("rst_re", reg_re, 0);
        chk("rst_err", frame_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frames
        wr_frame(7'h05, 16'h1234);
        rd_frame(7'h05);
        wr_frame(7'h7F, 16'hBEEF);
        rd_frame(7'h7F);
        rd_frame(7'h00);

        // TX-phase intrusion; err_clr in the same cycle as the error
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        chk("err_pre", frame_err, 0);
        clear_obs();
        a = 7'h21; oe0 = oe_cnt; re0 = re_cnt; bad0 = bad_cnt;
        start_read(a);
        link_data_in = 8'h11;
        strobe_in    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr   = 1'b0;
        strobe_in = 1'b0;
        chk("err_clr_vs_err", frame_err, 1);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        chk("err_clr_alone", frame_err, 0);
        repeat (30) @(negedge clk);
        rsp_check(a, oe0, re0, bad0);

        // Reset in the middle of the second STROBE phase, with an error pending
        clear_obs();
        start_read(7'h33);
        link_data_in = 8'h22;
        strobe_in    = 1'b1;
        repeat (3) @(negedge clk);
        strobe_in = 1'b0;
        for (int i = 0; i < 40 && rx_q.size() < 2; i++) @(negedge clk);
        @(negedge clk);
        chk("mid_strobe", strobe_out, 1);
        chk("pre_rst_err", frame_err, 1);
        #3 rst = 1'b1;
        #1;
        chk("arst_stb", strobe_out, 0);
        chk("arst_oe", link_data_oe, 0);
        chk("arst_err", frame_err, 0);
        clear_obs();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        oe0 = oe_cnt;
        repeat (20) @(negedge clk);
        chk("post_rst_quiet", oe_cnt - oe0, 0);
        wr_frame(7'h33, 16'hA5C3);
        rd_frame(7'h33);

`ifdef CCU25_TIMEOUT_EN
        // Stalled write frame is abandoned without a register write
        clear_obs();
        send_byte(8'h03);
        send_byte(8'hAA);
        repeat (TMO + 5) @(negedge clk);
        chk("tmo_err", frame_err, 1);
        chk("tmo_no_we", we_q.size(), 0);
        err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
        wr_frame(7'h03, 16'h0001);
        rd_frame(7'h03);
`endif

        // Randomized traffic
        for (int n = 0; n < 16; n++) begin
            a = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 0) wr_frame(a, 16'($urandom));
            else rd_frame(a);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
